// File: rtl/input_conditioner_if.sv
// Button/frame bundle between the board pins and the input conditioner.
// The master drives raw buttons and vsync; the slave returns frame-aligned commands.
interface input_conditioner_if;
  logic [4:0] buttons_raw;
  logic       vsync;
  logic [4:0] operation;
  logic [4:0] held;
  logic       frame_tick;

  modport master (
    output buttons_raw,
    output vsync,
    input  operation,
    input  held,
    input  frame_tick
  );

  modport slave (
    input  buttons_raw,
    input  vsync,
    output operation,
    output held,
    output frame_tick
  );
endinterface

// File: rtl/input_conditioner.sv
// Debounces five push-buttons and presents one frame's worth of commands per vsync.
// Define INPUT_AUTOREPEAT_EN to enable DAS/ARR auto-repeat on RIGHT, LEFT and DOWN.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DAS_FRAMES      = 10,
  parameter int ARR_FRAMES      = 3
) (
  input logic                clock,
  input logic                reset_n,
  input_conditioner_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DAS_FRAMES < 2 || DAS_FRAMES > 63 ||
      ARR_FRAMES < 1 || ARR_FRAMES > DAS_FRAMES) begin : g_bad_cfg
    $error("input_conditioner: parameter out of range");
  end

  logic [4:0]       btn_sync1_q, btn_sync2_q;
  logic             vs_sync1_q, vs_sync2_q, vs_prev_q;
  logic             frame_tick_q, frame_tick_d;
  logic [CNT_W-1:0] deb_cnt_q [5];
  logic [CNT_W-1:0] deb_cnt_d [5];
  logic [4:0]       held_q, held_d;
  logic [4:0]       pending_q, pending_d;
  logic [4:0]       operation_q, operation_d;
  logic [4:0]       rise_s, repeat_fire_s, emit_s;
  logic             cancel_s;

`ifdef INPUT_AUTOREPEAT_EN
  localparam logic [5:0] DAS_LAST   = 6'(DAS_FRAMES);
  localparam logic [5:0] ARR_RELOAD = 6'(DAS_FRAMES - ARR_FRAMES);
  logic [5:0] hold_cnt_q [3];
  logic [5:0] hold_cnt_d [3];
  logic [5:0] hold_inc_s [3];
`endif

  // Per-button debounce: the level only flips after DEBOUNCE_CYCLES of disagreement.
  always_comb begin
    held_d = held_q;
    for (int i = 0; i < 5; i++) begin
      if (btn_sync2_q[i] == held_q[i]) begin
        deb_cnt_d[i] = {CNT_W{1'b0}};
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_cnt_d[i] = {CNT_W{1'b0}};
        held_d[i]    = ~held_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
      end
    end
    rise_s       = held_d & ~held_q;
    frame_tick_d = vs_sync2_q & ~vs_prev_q;
  end

  // Frame assembly: repeat timers, opposing-direction cancel, press latching.
  always_comb begin
    repeat_fire_s = 5'b00000;
`ifdef INPUT_AUTOREPEAT_EN
    for (int i = 0; i < 3; i++) begin
      hold_inc_s[i] = hold_cnt_q[i] + 6'd1;
      if (!frame_tick_q) begin
        hold_cnt_d[i] = hold_cnt_q[i];
      end else if (pending_q[i] || !held_q[i]) begin
        hold_cnt_d[i] = 6'd0;
      end else if (hold_inc_s[i] == DAS_LAST) begin
        hold_cnt_d[i]    = ARR_RELOAD;
        repeat_fire_s[i] = 1'b1;
      end else begin
        hold_cnt_d[i] = hold_inc_s[i];
      end
    end
`endif
    emit_s   = pending_q | repeat_fire_s;
    cancel_s = emit_s[0] & emit_s[1];
    // A press edge landing on the tick survives into the next frame.
    if (frame_tick_q) begin
      operation_d = {emit_s[4:2], emit_s[1:0] & {2{~cancel_s}}};
      pending_d   = rise_s;
    end else begin
      operation_d = operation_q;
      pending_d   = pending_q | rise_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      btn_sync1_q  <= 5'b00000;
      btn_sync2_q  <= 5'b00000;
      vs_sync1_q   <= 1'b0;
      vs_sync2_q   <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      held_q       <= 5'b00000;
      pending_q    <= 5'b00000;
      operation_q  <= 5'b00000;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= {CNT_W{1'b0}};
`ifdef INPUT_AUTOREPEAT_EN
      for (int i = 0; i < 3; i++) hold_cnt_q[i] <= 6'd0;
`endif
    end else begin
      btn_sync1_q  <= bus.buttons_raw;
      btn_sync2_q  <= btn_sync1_q;
      vs_sync1_q   <= bus.vsync;
      vs_sync2_q   <= vs_sync1_q;
      vs_prev_q    <= vs_sync2_q;
      frame_tick_q <= frame_tick_d;
      held_q       <= held_d;
      pending_q    <= pending_d;
      operation_q  <= operation_d;
      for (int i = 0; i < 5; i++) deb_cnt_q[i] <= deb_cnt_d[i];
`ifdef INPUT_AUTOREPEAT_EN
      for (int i = 0; i < 3; i++) hold_cnt_q[i] <= hold_cnt_d[i];
`endif
    end
  end

  assign bus.operation  = operation_q;
  assign bus.held       = held_q;
  assign bus.frame_tick = frame_tick_q;
endmodule
